// File: rtl/axum_arb_pkg.sv
// Shared types and helpers for the axum host arbiter.
// Optional build macro: AXUM_ARB_LOCK_EN (adds the ARB_LOCKED state).
package axum_arb_pkg;

    localparam int MaxHosts = 32;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
`ifdef AXUM_ARB_LOCK_EN
        ARB_LOCKED = 2'd2,
`endif
        ARB_HOLD   = 2'd1
    } arb_state_e;

    function automatic int host_id_width(input int nr_hosts);
        return (nr_hosts > 1) ? $clog2(nr_hosts) : 1;
    endfunction

    // First set bit of mask at or after ptr, wrapping at n; returns ptr when mask is empty.
    function automatic int rr_pick(input logic [MaxHosts-1:0] mask, input int ptr, input int n);
        int   pick;
        logic found;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < MaxHosts; i++) begin
            int idx;
            idx = ptr + i;
            if (idx >= n) idx = idx - n;
            if (i < n && !found && mask[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/axum_arb_id_fifo.sv
// Synchronous FIFO of host IDs for outstanding transactions.
// Push is accepted while full when a pop happens in the same cycle.
module axum_arb_id_fifo #(
    parameter int Depth = 2,
    parameter int Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth) + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign head_o  = mem_q[rd_ptr_q];

    function automatic logic [PtrW-1:0] wrap_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    // NOTE: the storage array has no reset; pointers and count decide which entries are valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wrap_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= wrap_inc(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/axum_host_arb.sv
// Round-robin arbiter sharing one bus host port among NrHosts hosts, with in-order response routing.
// Optional build macro: AXUM_ARB_LOCK_EN (host_lock_i and exclusive ownership).
module axum_host_arb
    import axum_arb_pkg::*;
#(
    parameter int NrHosts        = 2,
    parameter int DataWidth      = 32,
    parameter int AddressWidth   = 32,
    parameter int MaxOutstanding = 2
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic [NrHosts-1:0]                    host_req_i,
    output logic [NrHosts-1:0]                    host_gnt_o,
    input  logic [NrHosts-1:0][AddressWidth-1:0]  host_addr_i,
    input  logic [NrHosts-1:0]                    host_we_i,
    input  logic [NrHosts-1:0][3:0]               host_be_i,
    input  logic [NrHosts-1:0][DataWidth-1:0]     host_wdata_i,
`ifdef AXUM_ARB_LOCK_EN
    input  logic [NrHosts-1:0]                    host_lock_i,
`endif
    output logic [NrHosts-1:0]                    host_rvalid_o,
    output logic [NrHosts-1:0][DataWidth-1:0]     host_rdata_o,
    output logic [NrHosts-1:0]                    host_err_o,
    output logic                                  dn_req_o,
    input  logic                                  dn_gnt_i,
    output logic [AddressWidth-1:0]               dn_addr_o,
    output logic                                  dn_we_o,
    output logic [3:0]                            dn_be_o,
    output logic [DataWidth-1:0]                  dn_wdata_o,
    input  logic                                  dn_rvalid_i,
    input  logic [DataWidth-1:0]                  dn_rdata_i,
    input  logic                                  dn_err_i,
    output logic                                  stray_rvalid_o
);

    localparam int IdW = host_id_width(NrHosts);
    typedef logic [IdW-1:0] host_id_t;

    arb_state_e state_q, state_d;
    host_id_t   ptr_q, ptr_d, hold_q, hold_d;
    host_id_t   winner, sel, head_id;
`ifdef AXUM_ARB_LOCK_EN
    host_id_t   owner_q, owner_d;
`endif
    logic       accept, in_lock, any_req, space, pop, fifo_full, fifo_empty;

    assign any_req = |host_req_i;
    assign winner  = host_id_t'(rr_pick(MaxHosts'(host_req_i), int'(ptr_q), NrHosts));
    // Outputs are held quiet while reset is asserted, independent of the clock.
    assign pop     = rst_ni && dn_rvalid_i && !fifo_empty;
    assign space   = !fifo_full || pop;

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_d     = hold_q;
`ifdef AXUM_ARB_LOCK_EN
        owner_d    = owner_q;
`endif
        sel        = winner;
        accept     = 1'b0;
        in_lock    = 1'b0;
        dn_req_o   = 1'b0;
        host_gnt_o = '0;
        if (rst_ni) begin
            case (state_q)
                ARB_IDLE: begin
                    if (any_req && space) begin
                        dn_req_o = 1'b1;
                        if (dn_gnt_i) begin
                            accept = 1'b1;
                        end else begin
                            state_d = ARB_HOLD;
                            hold_d  = winner;
                        end
                    end
                end
                ARB_HOLD: begin
                    sel = hold_q;
                    if (!host_req_i[hold_q]) begin
                        state_d = ARB_IDLE;
                    end else if (space) begin
                        dn_req_o = 1'b1;
                        if (dn_gnt_i) begin
                            accept  = 1'b1;
                            state_d = ARB_IDLE;
                        end
                    end
                end
`ifdef AXUM_ARB_LOCK_EN
                ARB_LOCKED: begin
                    sel     = owner_q;
                    in_lock = 1'b1;
                    if (!host_req_i[owner_q]) begin
                        if (fifo_empty) state_d = ARB_IDLE;
                    end else if (space) begin
                        dn_req_o = 1'b1;
                        if (dn_gnt_i) begin
                            accept = 1'b1;
                            if (!host_lock_i[owner_q]) state_d = ARB_IDLE;
                        end
                    end
                end
`endif
                default: state_d = ARB_IDLE;
            endcase
            if (accept) begin
                host_gnt_o[sel] = 1'b1;
                if (!in_lock) ptr_d = (sel == host_id_t'(NrHosts - 1)) ? '0 : sel + 1'b1;
`ifdef AXUM_ARB_LOCK_EN
                if (!in_lock && host_lock_i[sel]) begin
                    state_d = ARB_LOCKED;
                    owner_d = sel;
                end
`endif
            end
        end
    end

    assign dn_addr_o  = host_addr_i[sel];
    assign dn_we_o    = host_we_i[sel];
    assign dn_be_o    = host_be_i[sel];
    assign dn_wdata_o = host_wdata_i[sel];

    always_comb begin
        host_rvalid_o = '0;
        host_err_o    = '0;
        if (pop) begin
            host_rvalid_o[head_id] = 1'b1;
            host_err_o[head_id]    = dn_err_i;
        end
    end

    assign host_rdata_o   = {NrHosts{dn_rdata_i}};
    assign stray_rvalid_o = rst_ni && dn_rvalid_i && fifo_empty;

    axum_arb_id_fifo #(
        .Depth (MaxOutstanding),
        .Width (IdW)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (accept),
        .data_i  (sel),
        .pop_i   (pop),
        .head_o  (head_id),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ARB_IDLE;
            ptr_q   <= '0;
            hold_q  <= '0;
`ifdef AXUM_ARB_LOCK_EN
            owner_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
`ifdef AXUM_ARB_LOCK_EN
            owner_q <= owner_d;
`endif
        end
    end

endmodule

// File: tb/tb_axum_host_arb.sv
// Scoreboard bench for axum_host_arb: grants checked against a round-robin model, responses via a queue.
// Build with AXUM_ARB_LOCK_EN defined to include the lock scenario.
module tb_axum_host_arb;

    localparam int NrHosts        = 2;
    localparam int DataWidth      = 32;
    localparam int AddressWidth   = 32;
    localparam int MaxOutstanding = 2;

    typedef struct {
        int          host;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic                                  clk_i;
    logic                                  rst_ni;
    logic [NrHosts-1:0]                    host_req_i;
    logic [NrHosts-1:0]                    host_gnt_o;
    logic [NrHosts-1:0][AddressWidth-1:0]  host_addr_i;
    logic [NrHosts-1:0]                    host_we_i;
    logic [NrHosts-1:0][3:0]               host_be_i;
    logic [NrHosts-1:0][DataWidth-1:0]     host_wdata_i;
    logic [NrHosts-1:0]                    host_lock_i;
    logic [NrHosts-1:0]                    host_rvalid_o;
    logic [NrHosts-1:0][DataWidth-1:0]     host_rdata_o;
    logic [NrHosts-1:0]                    host_err_o;
    logic                                  dn_req_o;
    logic                                  dn_gnt_i;
    logic [AddressWidth-1:0]               dn_addr_o;
    logic                                  dn_we_o;
    logic [3:0]                            dn_be_o;
    logic [DataWidth-1:0]                  dn_wdata_o;
    logic                                  dn_rvalid_i;
    logic [DataWidth-1:0]                  dn_rdata_i;
    logic                                  dn_err_i;
    logic                                  stray_rvalid_o;

    exp_t exp_q[$];
    exp_t rsp_q[$];
    exp_t mon_e;
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   exp_ptr      = 0;

    axum_host_arb #(
        .NrHosts        (NrHosts),
        .DataWidth      (DataWidth),
        .AddressWidth   (AddressWidth),
        .MaxOutstanding (MaxOutstanding)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .host_req_i     (host_req_i),
        .host_gnt_o     (host_gnt_o),
        .host_addr_i    (host_addr_i),
        .host_we_i      (host_we_i),
        .host_be_i      (host_be_i),
        .host_wdata_i   (host_wdata_i),
`ifdef AXUM_ARB_LOCK_EN
        .host_lock_i    (host_lock_i),
`endif
        .host_rvalid_o  (host_rvalid_o),
        .host_rdata_o   (host_rdata_o),
        .host_err_o     (host_err_o),
        .dn_req_o       (dn_req_o),
        .dn_gnt_i       (dn_gnt_i),
        .dn_addr_o      (dn_addr_o),
        .dn_we_o        (dn_we_o),
        .dn_be_o        (dn_be_o),
        .dn_wdata_o     (dn_wdata_o),
        .dn_rvalid_i    (dn_rvalid_i),
        .dn_rdata_i     (dn_rdata_i),
        .dn_err_i       (dn_err_i),
        .stray_rvalid_o (stray_rvalid_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Response monitor: every host rvalid must match the oldest expected response.
    always @(negedge clk_i) begin
        if (rst_ni && (host_rvalid_o != '0)) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL unexpected_rvalid: got rvalid=%b, want none pending", host_rvalid_o);
            end else begin
                mon_e = exp_q.pop_front();
                if (host_rvalid_o !== (2'b01 << mon_e.host) ||
                    host_rdata_o[mon_e.host] !== mon_e.data ||
                    host_err_o !== (2'(mon_e.err) << mon_e.host)) begin
                    tests_failed++;
                    $display("FAIL response_route: got rvalid=%b err=%b rdata=%h, want host%0d err=%b rdata=%h",
                             host_rvalid_o, host_err_o, host_rdata_o[mon_e.host],
                             mon_e.host, mon_e.err, mon_e.data);
                end
            end
        end
    end

    function automatic int model_pick(input logic [1:0] req, input int ptr);
        if (req[ptr])       return ptr;
        if (req[1 - ptr])   return 1 - ptr;
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_expect(input int host, input logic [31:0] data, input logic err);
        exp_t e;
        e.host = host;
        e.data = data;
        e.err  = err;
        exp_q.push_back(e);
        rsp_q.push_back(e);
    endtask

    task automatic respond();
        exp_t r;
        if (rsp_q.size() > 0) begin
            r = rsp_q.pop_front();
            dn_rvalid_i = 1'b1;
            dn_rdata_i  = r.data;
            dn_err_i    = r.err;
        end else begin
            dn_rvalid_i = 1'b0;
            dn_rdata_i  = '0;
            dn_err_i    = 1'b0;
        end
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            host_req_i  = '0;
            dn_gnt_i    = 1'b0;
            host_lock_i = '0;
            respond();
            @(negedge clk_i);
        end
    endtask

    task automatic test_reset();
        rst_ni       = 1'b0;
        host_req_i   = 2'b11;
        host_lock_i  = '0;
        host_addr_i  = {32'h0000_2000, 32'h0000_1000};
        host_we_i    = 2'b10;
        host_be_i    = {4'hC, 4'h3};
        host_wdata_i = {32'hBBBB_0001, 32'hAAAA_0000};
        dn_gnt_i     = 1'b1;
        dn_rvalid_i  = 1'b1;
        dn_rdata_i   = '0;
        dn_err_i     = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        tests_run++;
        if ({host_gnt_o, dn_req_o, host_rvalid_o, host_err_o, stray_rvalid_o} !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_outputs: got gnt=%b req=%b rvalid=%b err=%b stray=%b, want all 0",
                     host_gnt_o, dn_req_o, host_rvalid_o, host_err_o, stray_rvalid_o);
        end
        tick();
        rst_ni      = 1'b1;
        host_req_i  = '0;
        dn_gnt_i    = 1'b0;
        dn_rvalid_i = 1'b0;
        dn_err_i    = 1'b0;
        exp_ptr     = 0;
        @(negedge clk_i);
        tests_run++;
        if ({host_gnt_o, dn_req_o, stray_rvalid_o} !== 4'h0) begin
            tests_failed++;
            $display("FAIL idle_after_reset: got gnt=%b req=%b stray=%b, want 0",
                     host_gnt_o, dn_req_o, stray_rvalid_o);
        end
    endtask

    task automatic test_single();
        tick();
        host_req_i = 2'b01;
        dn_gnt_i   = 1'b1;
        @(negedge clk_i);
        tests_run++;
        if (host_gnt_o !== 2'b01 || dn_req_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_grant: got gnt=%b req=%b, want gnt=01 req=1", host_gnt_o, dn_req_o);
        end
        tests_run++;
        if ({dn_addr_o, dn_we_o, dn_be_o, dn_wdata_o} !== {host_addr_i[0], host_we_i[0], host_be_i[0], host_wdata_i[0]}) begin
            tests_failed++;
            $display("FAIL single_fields: got addr=%h we=%b be=%h wdata=%h, want host0 fields",
                     dn_addr_o, dn_we_o, dn_be_o, dn_wdata_o);
        end
        push_expect(0, 32'hDEAD_BEEF, 1'b0);
        exp_ptr = 1;
        drain(2);
    endtask

    task automatic test_alternate();
        int w;
        for (int i = 0; i < 6; i++) begin
            tick();
            respond();
            host_req_i = 2'b11;
            dn_gnt_i   = 1'b1;
            w = model_pick(host_req_i, exp_ptr);
            @(negedge clk_i);
            tests_run++;
            if (host_gnt_o !== (2'b01 << w) || dn_addr_o !== host_addr_i[w]) begin
                tests_failed++;
                $display("FAIL alternate_%0d: got gnt=%b addr=%h, want host%0d addr=%h",
                         i, host_gnt_o, dn_addr_o, w, host_addr_i[w]);
            end
            push_expect(w, $urandom, i[0]);
            exp_ptr = (w + 1) % NrHosts;
        end
        drain(2);
    endtask

    task automatic test_hold();
        for (int i = 0; i < 4; i++) begin
            tick();
            respond();
            host_req_i = (i == 0) ? 2'b10 : 2'b11;
            dn_gnt_i   = (i == 3);
            @(negedge clk_i);
            tests_run++;
            if (dn_req_o !== 1'b1 || dn_addr_o !== host_addr_i[1] ||
                host_gnt_o !== ((i == 3) ? 2'b10 : 2'b00)) begin
                tests_failed++;
                $display("FAIL hold_%0d: got req=%b addr=%h gnt=%b, want req=1 addr=%h gnt=%b",
                         i, dn_req_o, dn_addr_o, host_gnt_o, host_addr_i[1], (i == 3) ? 2'b10 : 2'b00);
            end
        end
        push_expect(1, $urandom, 1'b1);
        exp_ptr = 0;
        tick();
        respond();
        host_req_i = 2'b01;
        dn_gnt_i   = 1'b1;
        @(negedge clk_i);
        tests_run++;
        if (host_gnt_o !== 2'b01) begin
            tests_failed++;
            $display("FAIL hold_release: got gnt=%b, want 01", host_gnt_o);
        end
        push_expect(0, $urandom, 1'b0);
        exp_ptr = 1;
        drain(2);
    endtask

    task automatic test_backpressure();
        int w;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 3) respond();
            else dn_rvalid_i = 1'b0;
            host_req_i = 2'b11;
            dn_gnt_i   = 1'b1;
            w = model_pick(host_req_i, exp_ptr);
            @(negedge clk_i);
            tests_run++;
            if (i == 2) begin
                if (host_gnt_o !== 2'b00 || dn_req_o !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL full_blocks: got gnt=%b req=%b, want gnt=00 req=0", host_gnt_o, dn_req_o);
                end
            end else begin
                if (host_gnt_o !== (2'b01 << w) || dn_req_o !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL bp_grant_%0d: got gnt=%b req=%b, want host%0d req=1", i, host_gnt_o, dn_req_o, w);
                end
                push_expect(w, $urandom, 1'b0);
                exp_ptr = (w + 1) % NrHosts;
            end
        end
        drain(3);
    endtask

    task automatic test_stray_reset();
        tick();
        dn_rvalid_i = 1'b1;
        dn_rdata_i  = 32'h5555_AAAA;
        @(negedge clk_i);
        tests_run++;
        if (stray_rvalid_o !== 1'b1 || host_rvalid_o !== 2'b00) begin
            tests_failed++;
            $display("FAIL stray_pulse: got stray=%b rvalid=%b, want stray=1 rvalid=00", stray_rvalid_o, host_rvalid_o);
        end
        tick();
        dn_rvalid_i = 1'b0;
        @(negedge clk_i);
        tests_run++;
        if (stray_rvalid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL stray_clear: got stray=%b, want 0", stray_rvalid_o);
        end
        tick();
        host_req_i = 2'b01;
        dn_gnt_i   = 1'b1;
        @(negedge clk_i);
        tests_run++;
        if (host_gnt_o !== 2'b01) begin
            tests_failed++;
            $display("FAIL pre_reset_grant: got gnt=%b, want 01", host_gnt_o);
        end
        tick();
        host_req_i  = 2'b11;
        dn_rvalid_i = 1'b1;
        #2 rst_ni = 1'b0;
        #1;
        tests_run++;
        if ({host_gnt_o, dn_req_o, host_rvalid_o, host_err_o, stray_rvalid_o} !== 8'h00) begin
            tests_failed++;
            $display("FAIL async_reset: got gnt=%b req=%b rvalid=%b err=%b stray=%b, want all 0",
                     host_gnt_o, dn_req_o, host_rvalid_o, host_err_o, stray_rvalid_o);
        end
        tick();
        tick();
        rst_ni      = 1'b1;
        host_req_i  = '0;
        dn_gnt_i    = 1'b0;
        dn_rvalid_i = 1'b1;
        exp_ptr     = 0;
        @(negedge clk_i);
        tests_run++;
        if (stray_rvalid_o !== 1'b1 || host_rvalid_o !== 2'b00) begin
            tests_failed++;
            $display("FAIL flushed_response: got stray=%b rvalid=%b, want stray=1 rvalid=00", stray_rvalid_o, host_rvalid_o);
        end
        tick();
        dn_rvalid_i = 1'b0;
        host_req_i  = 2'b11;
        dn_gnt_i    = 1'b1;
        @(negedge clk_i);
        tests_run++;
        if (host_gnt_o !== 2'b01) begin
            tests_failed++;
            $display("FAIL ptr_after_reset: got gnt=%b, want 01", host_gnt_o);
        end
        push_expect(0, $urandom, 1'b1);
        exp_ptr = 1;
        drain(2);
    endtask

`ifdef AXUM_ARB_LOCK_EN
    task automatic test_lock();
        logic [1:0] want;
        for (int i = 0; i < 5; i++) begin
            tick();
            respond();
            host_req_i  = (i == 0) ? 2'b01 : 2'b11;
            host_lock_i = (i < 3) ? 2'b01 : 2'b00;
            dn_gnt_i    = 1'b1;
            want        = (i < 4) ? 2'b01 : 2'b10;
            @(negedge clk_i);
            tests_run++;
            if (host_gnt_o !== want) begin
                tests_failed++;
                $display("FAIL lock_%0d: got gnt=%b, want %b", i, host_gnt_o, want);
            end
            push_expect((i < 4) ? 0 : 1, $urandom, 1'b0);
        end
        exp_ptr = 0;
        drain(2);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_hold();
        test_backpressure();
        test_stray_reset();
`ifdef AXUM_ARB_LOCK_EN
        test_lock();
`endif
        drain(2);
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL responses_missing: got %0d unanswered, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
